// File: rtl/sam_delay_search.sv
// Coarse symbol-timing acquisition: sweeps the sample-delay select, measures the
// mean absolute amplitude at symbol instants per candidate and locks onto the best.
module sam_delay_search #(
    parameter int MAX_DELAY  = 31,
    parameter int LOG2_N_SYM = 8,
    parameter int SETTLE_SYM = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic                    start,
    input  logic signed [17:0]      in,
    output logic [4:0]              delay,
    output logic                    busy,
    output logic                    done,
    output logic [16+LOG2_N_SYM:0]  best_metric
);

    localparam int AW      = 17 + LOG2_N_SYM;
    localparam int N_SYM   = 1 << LOG2_N_SYM;
    localparam int CNT_MAX = (SETTLE_SYM > N_SYM) ? SETTLE_SYM : N_SYM;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_ACCUM   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state_reg;
    logic [4:0]    cand_reg;
    logic [4:0]    best_delay_reg;
    logic [4:0]    delay_reg;
    logic [CW-1:0] cnt_reg;
    logic [AW-1:0] acc_reg;
    logic [AW-1:0] best_metric_reg;
    logic          busy_reg;
    logic          done_reg;

    logic          stb;
    logic [CW-1:0] cnt_inc;
    logic [17:0]   in_neg;
    logic [16:0]   abs_val;

    assign stb     = sam_clk_en & sym_clk_en;
    assign cnt_inc = cnt_reg + 1'b1;
    assign in_neg  = -in;

    // Only -131072 keeps bit 17 set after negation; it saturates to the 17-bit maximum.
    always_comb begin
        abs_val = in[16:0];
        if (in[17]) begin
            abs_val = in_neg[17] ? 17'h1FFFF : in_neg[16:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            cand_reg        <= '0;
            best_delay_reg  <= '0;
            delay_reg       <= '0;
            cnt_reg         <= '0;
            acc_reg         <= '0;
            best_metric_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cand_reg        <= '0;
                        delay_reg       <= '0;
                        best_delay_reg  <= '0;
                        best_metric_reg <= '0;
                        cnt_reg         <= '0;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    delay_reg <= cand_reg;
                    if (stb) begin
                        if (cnt_inc == CW'(SETTLE_SYM)) begin
                            cnt_reg   <= '0;
                            acc_reg   <= '0;
                            state_reg <= S_ACCUM;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                end
                S_ACCUM: begin
                    if (stb) begin
                        acc_reg <= acc_reg + AW'(abs_val);
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == CW'(N_SYM)) begin
                            state_reg <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    // Strict compare so ties stay with the earlier (smaller) delay.
                    if (cand_reg == '0 || acc_reg > best_metric_reg) begin
                        best_metric_reg <= acc_reg;
                        best_delay_reg  <= cand_reg;
                    end
                    cnt_reg <= '0;
                    if (cand_reg == 5'(MAX_DELAY)) begin
                        state_reg <= S_DONE;
                    end else begin
                        cand_reg  <= cand_reg + 5'd1;
                        state_reg <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    delay_reg <= best_delay_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign delay       = delay_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign best_metric = best_metric_reg;

endmodule

// File: tb/tb_sam_delay_search.sv
// Directed bench for sam_delay_search: a model delay line feeds back an amplitude
// chosen from the current delay select, and each sweep result is checked against a table.
module tb_sam_delay_search;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sam_clk_en;
    logic        sym_clk_en;
    logic        start;
    logic [17:0] din;
    logic [4:0]  delay;
    logic        busy;
    logic        done;
    logic [24:0] best_metric;

    always #5 clk = ~clk;

    sam_delay_search dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .start      (start),
        .in         (din),
        .delay      (delay),
        .busy       (busy),
        .done       (done),
        .best_metric(best_metric)
    );

    typedef struct {
        int    pd;       // delay that sees the peak value
        int    pv;       // value when delay == pd
        int    bv;       // value otherwise
        int    exp_d;
        int    exp_m;
        int    action;   // 0 none, 1 restart during cand 5, 2 gate enables during cand 9
        int    exp_cyc;  // clk edges from start sample to done visible
        string name;
    } vec_t;

    int          cur_pd, cur_pv, cur_bv;
    bit          rnd;
    logic [17:0] rnd_val;
    int          n_cmp = 0;
    int          n_err = 0;
    int          gate_left = 0;
    vec_t        tbl[6];

    // Model of the delay line: its output depends on the select driven by the DUT.
    always_comb begin
        din = (int'(delay) == cur_pd) ? 18'(cur_pv) : 18'(cur_bv);
        if (rnd) din = rnd_val;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_en(input int k);
        if (gate_left > 0) begin
            gate_left--;
            sam_clk_en = 1'b0;
            sym_clk_en = k[0];
        end else begin
            sam_clk_en = 1'b1;
            sym_clk_en = 1'b1;
        end
    endtask

    task automatic reset_seq(input string name);
        int bad;
        reset_n = 1'b0;
        rnd     = 1'b1;
        rnd_val = 18'($urandom);
        start   = 1'b1;
        #1;
        chk({name, ":delay"}, delay, 0);
        chk({name, ":busy"}, busy, 0);
        chk({name, ":done"}, done, 0);
        chk({name, ":metric"}, best_metric, 0);
        repeat (3) begin
            @(negedge clk);
            rnd_val    = 18'($urandom);
            sam_clk_en = 1'($urandom);
            sym_clk_en = 1'($urandom);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        start      = 1'b0;
        sam_clk_en = 1'b1;
        sym_clk_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy || done || delay != 5'd0) bad++;
            rnd_val = 18'($urandom);
        end
        chk({name, ":idle_after_release"}, bad, 0);
        rnd = 1'b0;
        $display("reset %s: delay=%0d busy=%0d metric=%0d", name, delay, busy, best_metric);
    endtask

    task automatic run_sweep(input vec_t v);
        int k, drops, at, ch, extra, target;
        bit seen;
        logic [4:0] d0;
        cur_pd = v.pd;
        cur_pv = v.pv;
        cur_bv = v.bv;
        rnd    = 1'b0;
        target = (v.action == 1) ? 5 : 9;
        sam_clk_en = 1'b1;
        sym_clk_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({v.name, ":busy_on"}, busy, 1);
        k = 0; drops = 0; at = 0; seen = 1'b0;
        while (!seen && k < 12000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) drops++;
            if (v.action != 0 && int'(delay) == target) begin
                at++;
                if (at == 100) begin
                    if (v.action == 1) start = 1'b1;
                    else gate_left = 1000;
                end
            end
            drive_en(k);
        end
        if (!seen) begin
            chk({v.name, ":done_timeout"}, 1, 0);
            return;
        end
        chk({v.name, ":cycles"}, k, v.exp_cyc);
        chk({v.name, ":busy_held"}, drops, 0);
        chk({v.name, ":delay"}, delay, v.exp_d);
        chk({v.name, ":metric"}, best_metric, v.exp_m);
        chk({v.name, ":busy_off"}, busy, 0);
        $display("sweep %s: delay=%0d metric=%0d cycles=%0d", v.name, delay, best_metric, k);
        d0 = delay; ch = 0; extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (delay != d0) ch++;
            if (done || busy) extra++;
            drive_en(k);
        end
        chk({v.name, ":delay_stable"}, ch, 0);
        chk({v.name, ":quiet_after"}, extra, 0);
    endtask

    initial begin
        int   k, at;
        vec_t cl;
        // 32 candidates x (4 settle + 256 accum + 1 compare) + DONE = 8353 edges
        tbl[0] = '{13, 1000, 100, 13, 256000, 1, 8353, "peak13_restart"};
        tbl[1] = '{5, 500, 500, 0, 128000, 0, 8353, "ties"};
        tbl[2] = '{7, -131072, 0, 7, 33554176, 0, 8353, "saturate"};
        tbl[3] = '{2, -5, 3, 2, 1280, 2, 9353, "sign_gated"};
        tbl[4] = '{31, 200, 199, 31, 51200, 0, 8353, "last_cand"};
        tbl[5] = '{20, 50, 60, 0, 15360, 0, 8353, "dip"};

        cur_pd = 0; cur_pv = 0; cur_bv = 0;
        rnd = 1'b0; rnd_val = '0;
        reset_n = 1'b0; start = 1'b0;
        sam_clk_en = 1'b0; sym_clk_en = 1'b0;
        @(negedge clk);
        reset_seq("power_on");

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i]);
        end

        // Abort partway through candidate 20's accumulation.
        cur_pd = 13; cur_pv = 1000; cur_bv = 100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; at = 0;
        while (at < 100 && k < 12000) begin
            @(negedge clk);
            k++;
            if (delay == 5'd20) at++;
            drive_en(k);
        end
        chk("abort:reach_cand20", at, 100);
        reset_seq("abort");

        cl = tbl[0];
        cl.action = 0;
        cl.name = "clean_after_abort";
        run_sweep(cl);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
